// File: rtl/req_ack_window_checker.sv
// -----------------------------------------------------------------------------
// req_ack_window_checker
//
// Multi-channel monitor for a req/ack handshake. For every channel it checks
// that each rising edge of ack arrives between MIN_DLY and MAX_DLY clock edges
// after the rising edge of req, and reports a per-channel verdict.
//
// Optional feature macro: STRAY_ACK_CHECK_EN
//   defined   -> an ack rise while a channel is idle is a fail with code 4
//   undefined -> idle ack rises are ignored (code 4 is never produced)
//
// Ports:
//   clk         clock, everything sampled on posedge
//   rst         asynchronous, active-high reset
//   en          global check enable; dropping it aborts open windows silently
//   clr         synchronous clear of counters and fail codes
//   req[NCH]    request per channel
//   ack[NCH]    acknowledge per channel
//   busy[NCH]   channel is inside a window (registered)
//   pass_pulse  one-cycle pass verdict per channel
//   fail_pulse  one-cycle fail verdict per channel
//   fail_code   3 bits per channel, last fail: 0 none, 1 early, 2 timeout,
//               3 overlap, 4 stray
//   pass_cnt    saturating count of all passes
//   fail_cnt    saturating count of all fails
// -----------------------------------------------------------------------------
module req_ack_window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 3,
    parameter int MAX_DLY = 3,
    parameter int TW      = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   ack,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   pass_pulse,
    output logic [NCH-1:0]   fail_pulse,
    output logic [3*NCH-1:0] fail_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int PW = $clog2(NCH + 1);
    localparam int SW = CNT_W + PW + 1;

    localparam logic [TW-1:0]    T_ZERO  = TW'(0);
    localparam logic [TW-1:0]    T_ONE   = TW'(1);
    localparam logic [TW-1:0]    T_MIN   = TW'(MIN_DLY);
    localparam logic [TW-1:0]    T_MAX   = TW'(MAX_DLY);
    localparam logic [SW-1:0]    CNT_SAT = SW'({CNT_W{1'b1}});

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_EARLY   = 3'd1;
    localparam logic [2:0] CODE_TIMEOUT = 3'd2;
    localparam logic [2:0] CODE_OVERLAP = 3'd3;
`ifdef STRAY_ACK_CHECK_EN
    localparam logic [2:0] CODE_STRAY   = 3'd4;
`endif

    // Illegal window configurations stop elaboration.
    generate
        if ((MIN_DLY < 0) || (MIN_DLY > MAX_DLY) || (MAX_DLY < 1) || (MAX_DLY >= (2 ** TW))) begin : g_param_check
            $fatal(1, "req_ack_window_checker: illegal MIN_DLY/MAX_DLY/TW combination");
        end
    endgenerate

    // Number of set bits in a channel vector.
    function automatic logic [PW-1:0] popcount(input logic [NCH-1:0] v);
        logic [PW-1:0] n;
        n = {PW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Counter plus increment, clamped at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PW-1:0] inc);
        logic [SW-1:0] s;
        s = SW'(c) + SW'(inc);
        if (s > CNT_SAT) begin
            return CNT_SAT[CNT_W-1:0];
        end else begin
            return s[CNT_W-1:0];
        end
    endfunction

    logic [NCH-1:0]   req_q_r;
    logic [NCH-1:0]   ack_q_r;
    logic [NCH-1:0]   rise_r_s;
    logic [NCH-1:0]   rise_a_s;
    state_t           state_r    [NCH];
    state_t           state_nx_s [NCH];
    logic [TW-1:0]    t_r        [NCH];
    logic [TW-1:0]    t_nx_s     [NCH];
    logic [TW-1:0]    t_cur_s    [NCH];
    logic [NCH-1:0]   pass_s;
    logic [NCH-1:0]   fail_s;
    logic [2:0]       code_s     [NCH];
    logic [NCH-1:0]   pass_pulse_r;
    logic [NCH-1:0]   fail_pulse_r;
    logic [3*NCH-1:0] fail_code_r;
    logic [3*NCH-1:0] fail_code_nx_s;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] fail_cnt_r;
    logic [CNT_W-1:0] pass_cnt_nx_s;
    logic [CNT_W-1:0] fail_cnt_nx_s;

    // Rising-edge detection against last cycle's inputs.
    always_comb begin
        rise_r_s = req & ~req_q_r;
        rise_a_s = ack & ~ack_q_r;
    end

    // Per-channel window FSM: next state, timer and verdict for this edge.
    // t_cur_s is the edge count since the req-rise edge as seen at this edge.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nx_s[i] = state_r[i];
            t_nx_s[i]     = t_r[i];
            t_cur_s[i]    = t_r[i] + T_ONE;
            pass_s[i]     = 1'b0;
            fail_s[i]     = 1'b0;
            code_s[i]     = CODE_NONE;
            case (state_r[i])
                ST_IDLE: begin
                    if (en && rise_r_s[i]) begin
                        state_nx_s[i] = ST_WAIT;
                        t_nx_s[i]     = T_ZERO;
                    end else begin
                        state_nx_s[i] = ST_IDLE;
                    end
`ifdef STRAY_ACK_CHECK_EN
                    if (en && rise_a_s[i]) begin
                        fail_s[i] = 1'b1;
                        code_s[i] = CODE_STRAY;
                    end else begin
                        fail_s[i] = 1'b0;
                    end
`endif
                end
                ST_WAIT: begin
                    if (!en) begin
                        state_nx_s[i] = ST_IDLE;
                    end else if (rise_a_s[i]) begin
                        // The ack is judged against the current window first; a
                        // simultaneous req rise then opens a fresh window.
                        if (t_cur_s[i] < T_MIN) begin
                            fail_s[i] = 1'b1;
                            code_s[i] = CODE_EARLY;
                        end else begin
                            pass_s[i] = 1'b1;
                        end
                        if (rise_r_s[i]) begin
                            state_nx_s[i] = ST_WAIT;
                            t_nx_s[i]     = T_ZERO;
                        end else begin
                            state_nx_s[i] = ST_IDLE;
                        end
                    end else if (rise_r_s[i]) begin
                        // A new request before any ack wins over a same-edge
                        // timeout: report overlap and restart the window.
                        fail_s[i]     = 1'b1;
                        code_s[i]     = CODE_OVERLAP;
                        state_nx_s[i] = ST_WAIT;
                        t_nx_s[i]     = T_ZERO;
                    end else if (t_cur_s[i] == T_MAX) begin
                        fail_s[i]     = 1'b1;
                        code_s[i]     = CODE_TIMEOUT;
                        state_nx_s[i] = ST_IDLE;
                    end else begin
                        t_nx_s[i] = t_cur_s[i];
                    end
                end
                default: begin
                    state_nx_s[i] = ST_IDLE;
                    t_nx_s[i]     = T_ZERO;
                end
            endcase
        end
    end

    // Next fail codes: clr wipes all fields, otherwise a fail overwrites its field.
    always_comb begin
        fail_code_nx_s = fail_code_r;
        if (clr) begin
            fail_code_nx_s = {(3*NCH){1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fail_s[i]) begin
                    fail_code_nx_s[3*i +: 3] = code_s[i];
                end else begin
                    fail_code_nx_s[3*i +: 3] = fail_code_r[3*i +: 3];
                end
            end
        end
    end

    // Next counter values: clr has priority over this cycle's verdicts.
    always_comb begin
        if (clr) begin
            pass_cnt_nx_s = {CNT_W{1'b0}};
            fail_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
            pass_cnt_nx_s = sat_add(pass_cnt_r, popcount(pass_s));
            fail_cnt_nx_s = sat_add(fail_cnt_r, popcount(fail_s));
        end
    end

    // Edge registers and channel FSM state; edge registers track inputs even when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q_r <= {NCH{1'b0}};
            ack_q_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= ST_IDLE;
                t_r[i]     <= T_ZERO;
            end
        end else begin
            req_q_r <= req;
            ack_q_r <= ack;
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= state_nx_s[i];
                t_r[i]     <= t_nx_s[i];
            end
        end
    end

    // Registered verdict pulses, fail codes and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_pulse_r <= {NCH{1'b0}};
            fail_pulse_r <= {NCH{1'b0}};
            fail_code_r  <= {(3*NCH){1'b0}};
            pass_cnt_r   <= {CNT_W{1'b0}};
            fail_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            pass_pulse_r <= pass_s;
            fail_pulse_r <= fail_s;
            fail_code_r  <= fail_code_nx_s;
            pass_cnt_r   <= pass_cnt_nx_s;
            fail_cnt_r   <= fail_cnt_nx_s;
        end
    end

    // busy is decoded straight from the state register.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_r[i] == ST_WAIT);
        end
    end

    assign pass_pulse = pass_pulse_r;
    assign fail_pulse = fail_pulse_r;
    assign fail_code  = fail_code_r;
    assign pass_cnt   = pass_cnt_r;
    assign fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_req_ack_window_checker.sv
// -----------------------------------------------------------------------------
// tb_req_ack_window_checker
//
// Two checker instances share one set of stimulus: dut_a with the default
// window [3,3] and 16-bit counters, dut_b with window [2,5] and 2-bit counters.
// A behavioural model that tracks open windows by their start edge index
// predicts every output of both instances after every clock edge. A table of
// hand-computed vectors and a few hand-written sequences cover the directed
// cases; a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_req_ack_window_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  req;
    logic [3:0]  ack;

    logic [3:0]  busy_a, pass_a, fail_a;
    logic [11:0] code_a;
    logic [15:0] pcnt_a, fcnt_a;
    logic [3:0]  busy_b, pass_b, fail_b;
    logic [11:0] code_b;
    logic [1:0]  pcnt_b, fcnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    req_ack_window_checker #(
        .NCH(4), .MIN_DLY(3), .MAX_DLY(3), .TW(8), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack),
        .busy(busy_a), .pass_pulse(pass_a), .fail_pulse(fail_a),
        .fail_code(code_a), .pass_cnt(pcnt_a), .fail_cnt(fcnt_a)
    );

    req_ack_window_checker #(
        .NCH(4), .MIN_DLY(2), .MAX_DLY(5), .TW(4), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack),
        .busy(busy_b), .pass_pulse(pass_b), .fail_pulse(fail_b),
        .fail_code(code_b), .pass_cnt(pcnt_b), .fail_cnt(fcnt_b)
    );

`ifdef STRAY_ACK_CHECK_EN
    localparam bit STRAY = 1'b1;
`else
    localparam bit STRAY = 1'b0;
`endif

    // ---------------- behavioural reference model ----------------
    int       m_mn    [2];
    int       m_mx    [2];
    int       m_sat   [2];
    bit       m_open  [2][4];
    int       m_start [2][4];
    int       m_code  [2][4];
    int       m_pc    [2];
    int       m_fc    [2];
    bit [3:0] m_pass  [2];
    bit [3:0] m_fail  [2];
    bit [3:0] m_pq;
    bit [3:0] m_pa;
    int       m_n = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_open[k][ch] = 1'b0;
                m_code[k][ch] = 0;
            end
            m_pc[k]   = 0;
            m_fc[k]   = 0;
            m_pass[k] = 4'h0;
            m_fail[k] = 4'h0;
        end
        m_pq = 4'h0;
        m_pa = 4'h0;
    endtask

    // One clock edge: windows are remembered by the edge index they opened at.
    task automatic model_step(input bit e, input bit c, input bit [3:0] rq, input bit [3:0] ak);
        bit [3:0] rr;
        bit [3:0] ra;
        int       age;
        int       np;
        int       nf;
        rr   = rq & ~m_pq;
        ra   = ak & ~m_pa;
        m_pq = rq;
        m_pa = ak;
        m_n++;
        for (int k = 0; k < 2; k++) begin
            np = 0;
            nf = 0;
            m_pass[k] = 4'h0;
            m_fail[k] = 4'h0;
            for (int ch = 0; ch < 4; ch++) begin
                int vcode;
                vcode = 0;
                if (m_open[k][ch]) begin
                    age = m_n - m_start[k][ch];
                    if (!e) begin
                        m_open[k][ch] = 1'b0;
                    end else if (ra[ch]) begin
                        if (age < m_mn[k]) vcode = 1;
                        else m_pass[k][ch] = 1'b1;
                        m_open[k][ch]  = rr[ch];
                        m_start[k][ch] = m_n;
                    end else if (rr[ch]) begin
                        vcode = 3;
                        m_start[k][ch] = m_n;
                    end else if (age == m_mx[k]) begin
                        vcode = 2;
                        m_open[k][ch] = 1'b0;
                    end
                end else if (e) begin
                    if (rr[ch]) begin
                        m_open[k][ch]  = 1'b1;
                        m_start[k][ch] = m_n;
                    end
                    if (STRAY && ra[ch]) vcode = 4;
                end
                if (vcode != 0) begin
                    m_fail[k][ch] = 1'b1;
                    m_code[k][ch] = vcode;
                end
                np += int'(m_pass[k][ch]);
                nf += int'(m_fail[k][ch]);
            end
            if (c) begin
                m_pc[k] = 0;
                m_fc[k] = 0;
                for (int ch = 0; ch < 4; ch++) m_code[k][ch] = 0;
            end else begin
                m_pc[k] = (m_pc[k] + np > m_sat[k]) ? m_sat[k] : m_pc[k] + np;
                m_fc[k] = (m_fc[k] + nf > m_sat[k]) ? m_sat[k] : m_fc[k] + nf;
            end
        end
    endtask

    function automatic logic [3:0] m_busy(input int k);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch] = m_open[k][ch];
        return v;
    endfunction

    function automatic logic [11:0] m_codes(input int k);
        logic [11:0] v;
        for (int ch = 0; ch < 4; ch++) v[3*ch +: 3] = 3'(m_code[k][ch]);
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("A busy",       64'(busy_a), 64'(m_busy(0)));
        chk("A pass_pulse", 64'(pass_a), 64'(m_pass[0]));
        chk("A fail_pulse", 64'(fail_a), 64'(m_fail[0]));
        chk("A fail_code",  64'(code_a), 64'(m_codes(0)));
        chk("A pass_cnt",   64'(pcnt_a), 64'(m_pc[0]));
        chk("A fail_cnt",   64'(fcnt_a), 64'(m_fc[0]));
        chk("B busy",       64'(busy_b), 64'(m_busy(1)));
        chk("B pass_pulse", 64'(pass_b), 64'(m_pass[1]));
        chk("B fail_pulse", 64'(fail_b), 64'(m_fail[1]));
        chk("B fail_code",  64'(code_b), 64'(m_codes(1)));
        chk("B pass_cnt",   64'(pcnt_b), 64'(m_pc[1]));
        chk("B fail_cnt",   64'(fcnt_b), 64'(m_fc[1]));
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, check 1 ns later.
    task automatic cyc(input logic e, input logic c, input logic [3:0] rq, input logic [3:0] ak);
        en  = e;
        clr = c;
        req = rq;
        ack = ak;
        @(posedge clk);
        model_step(e, c, rq, ak);
        #1;
        check_model();
        @(negedge clk);
    endtask

    // Assert reset between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table (dut_a, window [3,3]) ----------------
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [3:0]  x_pass;
        logic [3:0]  x_fail;
        logic [3:0]  x_busy;
        logic [11:0] x_code;
        int          x_pc;
        int          x_fc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [3:0] rq;
        logic [3:0] ak;

        m_mn[0] = 3; m_mx[0] = 3; m_sat[0] = 65535;
        m_mn[1] = 2; m_mx[1] = 5; m_sat[1] = 3;
        rst = 1'b0; en = 1'b0; clr = 1'b0; req = 4'h0; ack = 4'h0;

        // ch0: req rises, ack at t=3 -> pass. ch1: ack at t=2 -> early, then no ack -> timeout.
        tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 0, 0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 12'h000, 0, 0};
        tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 12'h000, 0, 0};
        tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 12'h000, 0, 0};
        tbl[4]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 12'h000, 1, 0};
        tbl[5]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 1, 0};
        tbl[6]  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 12'h000, 1, 0};
        tbl[7]  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 12'h000, 1, 0};
        tbl[8]  = '{4'h2, 4'h2, 4'h0, 4'h2, 4'h0, 12'h008, 1, 1};
        tbl[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h008, 1, 1};
        tbl[10] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 12'h008, 1, 1};
        tbl[11] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 12'h008, 1, 1};
        tbl[12] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 12'h008, 1, 1};
        tbl[13] = '{4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 12'h010, 1, 2};
        tbl[14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h010, 1, 2};

        @(negedge clk);
        do_reset();

        for (int v = 0; v < 15; v++) begin
            cyc(1'b1, 1'b0, tbl[v].req, tbl[v].ack);
            chk("tbl pass_pulse", 64'(pass_a), 64'(tbl[v].x_pass));
            chk("tbl fail_pulse", 64'(fail_a), 64'(tbl[v].x_fail));
            chk("tbl busy",       64'(busy_a), 64'(tbl[v].x_busy));
            chk("tbl fail_code",  64'(code_a), 64'(tbl[v].x_code));
            chk("tbl pass_cnt",   64'(pcnt_a), 64'(tbl[v].x_pc));
            chk("tbl fail_cnt",   64'(fcnt_a), 64'(tbl[v].x_fc));
        end

        // dut_b window [2,5] on ch3: pass at t=2, pass at t=5, timeout at t=5 then late ack.
        do_reset();
        cyc(1'b1, 1'b0, 4'h8, 4'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h8);
        chk("win25 pass t2", 64'(pass_b[3]), 64'd1);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h0);
        for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 4'h8, 4'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h8);
        chk("win25 pass t5", 64'(pass_b[3]), 64'd1);
        chk("win25 pass_cnt", 64'(pcnt_b), 64'd2);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h0);
        for (int j = 0; j < 5; j++) cyc(1'b1, 1'b0, 4'h8, 4'h0);
        chk("win25 timeout pulse", 64'(fail_b[3]), 64'd1);
        chk("win25 timeout code", 64'(code_b[11:9]), 64'd2);
        chk("win25 idle after timeout", 64'(busy_b[3]), 64'd0);
        cyc(1'b1, 1'b0, 4'h8, 4'h8);
        chk("win25 late ack pass", 64'(pass_b[3]), 64'd0);
        chk("win25 late ack fail", 64'(fail_b[3]), STRAY ? 64'd1 : 64'd0);
        chk("win25 late ack code", 64'(code_b[11:9]), STRAY ? 64'd4 : 64'd2);

        // dut_a ch2: overlap at t=2, pass at t=3, then ack and req rising together.
        do_reset();
        cyc(1'b1, 1'b0, 4'h4, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h4, 4'h0);
        chk("overlap pulse", 64'(fail_a[2]), 64'd1);
        chk("overlap code", 64'(code_a[8:6]), 64'd3);
        chk("overlap reopens", 64'(busy_a[2]), 64'd1);
        cyc(1'b1, 1'b0, 4'h4, 4'h0);
        cyc(1'b1, 1'b0, 4'h4, 4'h0);
        cyc(1'b1, 1'b0, 4'h4, 4'h4);
        chk("pass after overlap", 64'(pass_a[2]), 64'd1);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h4, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h4, 4'h4);
        chk("same-edge pass", 64'(pass_a[2]), 64'd1);
        chk("same-edge no fail", 64'(fail_a[2]), 64'd0);
        chk("same-edge new window", 64'(busy_a[2]), 64'd1);
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 4'h4, 4'h4);
        chk("same-edge window times out", 64'(fail_a[2]), 64'd1);

        // Reset in the middle of a window, then an ack rise while idle.
        cyc(1'b1, 1'b0, 4'h1, 4'h0);
        cyc(1'b1, 1'b0, 4'h1, 4'h0);
        chk("pre-reset busy", 64'(busy_a[0]), 64'd1);
        do_reset();
        chk("reset busy", 64'(busy_a), 64'd0);
        chk("reset pass_cnt", 64'(pcnt_a), 64'd0);
        chk("reset fail_cnt", 64'(fcnt_a), 64'd0);
        cyc(1'b1, 1'b0, 4'h0, 4'h1);
        chk("idle ack pass", 64'(pass_a[0]), 64'd0);
        chk("idle ack fail", 64'(fail_a[0]), STRAY ? 64'd1 : 64'd0);
        chk("idle ack code", 64'(code_a[2:0]), STRAY ? 64'd4 : 64'd0);
        chk("idle ack fail_cnt", 64'(fcnt_a), STRAY ? 64'd1 : 64'd0);

        // dut_b 2-bit counters: four simultaneous timeouts saturate; clr beats a pass.
        do_reset();
        for (int j = 0; j < 6; j++) cyc(1'b1, 1'b0, 4'hF, 4'h0);
        chk("sat fail_pulse", 64'(fail_b), 64'hF);
        chk("sat fail_cnt", 64'(fcnt_b), 64'd3);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h1, 4'h0);
        cyc(1'b1, 1'b0, 4'h1, 4'h0);
        cyc(1'b1, 1'b1, 4'h1, 4'h1);
        chk("clr with pass pulse", 64'(pass_b[0]), 64'd1);
        chk("clr with pass cnt", 64'(pcnt_b), 64'd0);
        chk("clr fail_cnt", 64'(fcnt_b), 64'd0);

        // Randomized traffic against the model, with occasional reset, clr and disable.
        do_reset();
        rq = 4'h0;
        ak = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 4) == 0) rq[c] = ~rq[c];
                    if ($urandom_range(0, 3) == 0) ak[c] = ~ak[c];
                end
                cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 49) == 0), rq, ak);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/req_ack_window_checker.md
Name: req_ack_window_checker

Overview:
- Synthesisable multi-channel monitor for the req/ack handshake.
- For each channel, checks that every rising edge of ack arrives within a cycle window [MIN_DLY, MAX_DLY] after the rising edge of req.
- Generalises the fixed "ack rises 3 cycles after req" property to parametrised channels, windows and counters, with per-channel verdicts.
- Sits beside handshake interfaces in simulation and FPGA debug builds; its outputs feed status registers and testbench scoreboards.

Parameters:
- NCH, 4, number of independent req/ack channels.
- MIN_DLY, 3, earliest legal ack-rise delay in clk edges after the req-rise edge.
- MAX_DLY, 3, latest legal delay. Constraints: MIN_DLY <= MAX_DLY, MAX_DLY >= 1, MAX_DLY < 2**TW. Checked at elaboration; a violation is a fatal error.
- TW, 8, width of each per-channel timer.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global check enable.
- clr  in  1  synchronous clear of counters and fail codes.
- req  in  NCH  request per channel.
- ack  in  NCH  acknowledge per channel.
- busy  out  NCH  channel is inside a window.
- pass_pulse  out  NCH  one-cycle pass verdict.
- fail_pulse  out  NCH  one-cycle fail verdict.
- fail_code  out  3*NCH  last fail code per channel. 0 none, 1 early, 2 timeout, 3 overlap, 4 stray.
- pass_cnt  out  CNT_W  total passes, saturating.
- fail_cnt  out  CNT_W  total fails, saturating.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - All channels are in IDLE.
  - Edge registers req_q and ack_q are 0, so a req held high at the first post-reset edge counts as a rise.
- Edge detection:
  - rise_r = req & ~req_q; rise_a = ack & ~ack_q.
  - Evaluated at each posedge; req_q and ack_q update every cycle regardless of en.
- Per-channel FSM, states IDLE and WAIT:
  - IDLE: if en and rise_r, go to WAIT with t = 0 (t counts edges since the req-rise edge). An ack rise in IDLE is ignored, unless the optional feature is enabled.
  - WAIT: t increments every edge. Decision at edge t:
    - rise_a with t < MIN_DLY: fail, code 1, go to IDLE.
    - rise_a with MIN_DLY <= t <= MAX_DLY: pass, go to IDLE.
    - No rise_a at t = MAX_DLY: fail, code 2, go to IDLE.
    - rise_r at t >= 1 with no rise_a at that edge: fail, code 3; restart WAIT with t = 0 (new window).
    - rise_a and rise_r on the same edge: first resolve the ack against the old window (pass or early), then open a new window with t = 0. No overlap fail is raised.
    - en deasserted: abort to IDLE at that edge, no verdict.
- Outputs:
  - Verdicts are registered: pass_pulse and fail_pulse go high for exactly one cycle, starting one cycle after the deciding edge.
  - fail_code updates together with fail_pulse and holds until the next fail on that channel, clr, or rst.
  - busy = (state == WAIT), registered.
- Counters:
  - pass_cnt adds the popcount of that cycle's pass verdicts; fail_cnt adds the popcount of fail verdicts. Both saturate at 2**CNT_W - 1.
  - clr zeroes both counters and all fail_code fields. It has priority over the same-cycle increment, does not touch FSMs or pulses, and has no effect on channel timing.
- Reset mid-operation: all windows are dropped with no verdict. An ack rising after reset release is treated as an IDLE ack.
- Channels are fully independent; there is no cross-channel priority.

Optional Feature:
- STRAY_ACK_CHECK_EN
- Defined: rise_a in IDLE (including on the edge a channel returns to IDLE from a timeout) gives fail_pulse, code 4, and increments fail_cnt.
- Undefined: IDLE ack rises are ignored, and code 4 is never produced.

Test Plan:
1. Defaults; req[0] rises at edge 1, ack[0] rises at edge 4 -> pass_pulse[0] high for one cycle after edge 4; pass_cnt=1, fail_cnt=0, busy[0] high during edges 2-4.
2. Defaults; ack[1] rises at t=2 -> fail_pulse[1], fail_code[1]=1, fail_cnt=1. Repeat with no ack -> timeout at t=3, code 2, fail_cnt=2.
3. MIN_DLY=2, MAX_DLY=5; req rises, ack rises at t=2, then again on a second request at t=5 -> 2 passes. A third request with ack at t=6 -> no verdict at the ack edge because the channel is already IDLE after the timeout fail at t=5, code 2.
4. req[2] rises at edge 0 and again at edge 2, ack rises at edge 5 -> overlap fail at edge 2 (code 3), pass at edge 5. Next, ack rise and req rise on the same edge -> pass, then a new window opens.
5. CNT_W=2; all 4 channels time out on the same edge -> fail_cnt=3 (saturated). clr asserted together with a pass -> pass_cnt=0 next cycle.
6. rst at t=1 of a window -> outputs 0 immediately. Ack rise after release gives no verdict without the macro; with STRAY_ACK_CHECK_EN it gives code 4 and fail_cnt=1.
